// File: rtl/reg_access_arbiter_pkg.sv
// Shared types and constants for the modulator register-bank access arbiter.
// Port ids and state encodings match those used by the SPI interface and the register bank.
package reg_access_arbiter_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam logic [ADDR_W-1:0] CTRL_ADDR = 10'd512;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        PORT_HOST = 1'b0,
        PORT_CORE = 1'b1
    } port_id_t;

    // The control register (enable/mapping bits) may only be written from the host.
    function automatic logic write_blocked(port_id_t port, logic write, logic [ADDR_W-1:0] addr);
        return (port == PORT_CORE) && write && (addr == CTRL_ADDR);
    endfunction

endpackage

// File: rtl/reg_access_arbiter_if.sv
// One requester port: request channel (valid/ready) plus read-response channel (valid/ready).
// The requester uses the master modport; the arbiter uses the slave modport.
interface reg_access_arbiter_if;
    import reg_access_arbiter_pkg::*;

    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_ready;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/reg_access_arbiter_rr2.sv
// Two-way round-robin grant: a sole requester wins; a tie goes to the port not granted last.
module reg_access_arbiter_rr2
    import reg_access_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  port_id_t   last_grant,
    output port_id_t   grant
);

    always_comb begin
        grant = PORT_HOST;
        if (req == 2'b11) begin
            if (last_grant == PORT_HOST) grant = PORT_CORE;
        end else if (req[PORT_CORE]) begin
            grant = PORT_CORE;
        end
    end

endmodule

// File: rtl/reg_access_arbiter.sv
// Shares the modulator register bank between host and core: round-robin grant, one transaction
// in flight, posted writes, reads returned on the granted port's response channel.
module reg_access_arbiter
    import reg_access_arbiter_pkg::*;
#(
    parameter int READ_LATENCY = 1
)
(
    input  logic                 clk,
    input  logic                 rst,
    reg_access_arbiter_if.slave  host,
    reg_access_arbiter_if.slave  core,
    output logic                 core_wr_reject,
    output logic [ADDR_W-1:0]    bank_addr,
    output logic [DATA_W-1:0]    bank_wdata,
    output logic                 bank_we,
    output logic                 bank_re,
    input  logic [DATA_W-1:0]    bank_rdata
);

    localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);

    state_t            state;
    port_id_t          grant;
    port_id_t          last_grant;
    port_id_t          next_grant;
    logic [2:0]        lat_cnt;
    logic              rd_pending;
    logic [1:0]        req;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_blocked;
    logic              rsp_ready_g;

    assign req = {core.req_valid, host.req_valid};

    reg_access_arbiter_rr2 u_rr2 (
        .req        (req),
        .last_grant (last_grant),
        .grant      (next_grant)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel_write = host.req_write;
        sel_addr  = host.req_addr;
        sel_wdata = host.req_wdata;
        if (next_grant == PORT_CORE) begin
            sel_write = core.req_write;
            sel_addr  = core.req_addr;
            sel_wdata = core.req_wdata;
        end
    end

    assign sel_blocked = write_blocked(next_grant, sel_write, sel_addr);
    assign rsp_ready_g = (grant == PORT_HOST) ? host.rsp_ready : core.rsp_ready;

    // NOTE: state uses non-blocking assignments; the pulse outputs default low each cycle and
    // are only raised on the transition into ISSUE, so they last exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            grant          <= PORT_HOST;
            last_grant     <= PORT_CORE;
            lat_cnt        <= '0;
            rd_pending     <= 1'b0;
            host.req_ready <= 1'b0;
            host.rsp_valid <= 1'b0;
            host.rsp_data  <= '0;
            core.req_ready <= 1'b0;
            core.rsp_valid <= 1'b0;
            core.rsp_data  <= '0;
            core_wr_reject <= 1'b0;
            bank_addr      <= '0;
            bank_wdata     <= '0;
            bank_we        <= 1'b0;
            bank_re        <= 1'b0;
        end else begin
            host.req_ready <= 1'b0;
            core.req_ready <= 1'b0;
            core_wr_reject <= 1'b0;
            bank_we        <= 1'b0;
            bank_re        <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        grant          <= next_grant;
                        last_grant     <= next_grant;
                        bank_addr      <= sel_addr;
                        bank_wdata     <= sel_wdata;
                        bank_we        <= sel_write && !sel_blocked;
                        bank_re        <= !sel_write;
                        core_wr_reject <= sel_blocked;
                        host.req_ready <= (next_grant == PORT_HOST);
                        core.req_ready <= (next_grant == PORT_CORE);
                        rd_pending     <= !sel_write;
                        state          <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (rd_pending) begin
                        lat_cnt <= LAT_LOAD;
                        state   <= ST_WAIT;
                    end else begin
                        state   <= ST_IDLE;
                    end
                end

                ST_WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        if (grant == PORT_HOST) begin
                            host.rsp_data  <= bank_rdata;
                            host.rsp_valid <= 1'b1;
                        end else begin
                            core.rsp_data  <= bank_rdata;
                            core.rsp_valid <= 1'b1;
                        end
                        state <= ST_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready_g) begin
                        host.rsp_valid <= 1'b0;
                        core.rsp_valid <= 1'b0;
                        rd_pending     <= 1'b0;
                        state          <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter: one DUT at READ_LATENCY=1, a second at READ_LATENCY=3.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
module tb_reg_access_arbiter;
    import reg_access_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    reg_access_arbiter_if host_if ();
    reg_access_arbiter_if core_if ();
    reg_access_arbiter_if h3_if ();
    reg_access_arbiter_if c3_if ();

    logic              core_wr_reject, bank_we, bank_re;
    logic [ADDR_W-1:0] bank_addr;
    logic [DATA_W-1:0] bank_wdata, bank_rdata;
    logic              core_wr_reject3, bank_we3, bank_re3;
    logic [ADDR_W-1:0] bank_addr3;
    logic [DATA_W-1:0] bank_wdata3, bank_rdata3;

    reg_access_arbiter #(.READ_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .host(host_if.slave), .core(core_if.slave),
        .core_wr_reject(core_wr_reject), .bank_addr(bank_addr), .bank_wdata(bank_wdata),
        .bank_we(bank_we), .bank_re(bank_re), .bank_rdata(bank_rdata)
    );

    reg_access_arbiter #(.READ_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .host(h3_if.slave), .core(c3_if.slave),
        .core_wr_reject(core_wr_reject3), .bank_addr(bank_addr3), .bank_wdata(bank_wdata3),
        .bank_we(bank_we3), .bank_re(bank_re3), .bank_rdata(bank_rdata3)
    );

    function automatic logic [63:0] dut_outs();
        return 64'({host_if.req_ready, host_if.rsp_valid, host_if.rsp_data,
                    core_if.req_ready, core_if.rsp_valid, core_if.rsp_data,
                    core_wr_reject, bank_addr, bank_wdata, bank_we, bank_re});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (dut_outs() !== 64'd0) begin bad++; $display("FAIL reset_idle cyc=%0d got=%h want=0", i, dut_outs()); end
            tick();
        end
        bank_rdata = 8'h5A;
        host_if.req_valid = 1'b1; host_if.req_write = 1'b0; host_if.req_addr = 10'h010;
        @(negedge clk);
        total++; if (host_if.req_ready !== 1'b0) begin bad++; $display("FAIL t1_ready_c0 got=%b want=0", host_if.req_ready); end
        tick(); @(negedge clk);
        total++; if (host_if.req_ready !== 1'b1) begin bad++; $display("FAIL t1_ready_c1 got=%b want=1", host_if.req_ready); end
        total++; if (bank_re !== 1'b1) begin bad++; $display("FAIL t1_bank_re got=%b want=1", bank_re); end
        total++; if (bank_addr !== 10'h010) begin bad++; $display("FAIL t1_bank_addr got=%h want=010", bank_addr); end
        host_if.req_valid = 1'b0;
        tick(); @(negedge clk);
        total++; if (host_if.rsp_valid !== 1'b0) begin bad++; $display("FAIL t1_rsp_valid_c2 got=%b want=0", host_if.rsp_valid); end
        tick(); @(negedge clk);
        total++; if (host_if.rsp_valid !== 1'b1) begin bad++; $display("FAIL t1_rsp_valid_c3 got=%b want=1", host_if.rsp_valid); end
        total++; if (host_if.rsp_data !== 8'h5A) begin bad++; $display("FAIL t1_rsp_data got=%h want=5a", host_if.rsp_data); end
        tick(); @(negedge clk);
        total++; if (host_if.rsp_valid !== 1'b0) begin bad++; $display("FAIL t1_rsp_valid_c4 got=%b want=0", host_if.rsp_valid); end
        tick();
    endtask

    task automatic test_round_robin();
        rst = 1'b1; tick(); rst = 1'b0;
        bank_rdata = 8'h77;
        host_if.req_valid = 1'b1; host_if.req_write = 1'b0; host_if.req_addr = 10'h020;
        core_if.req_valid = 1'b1; core_if.req_write = 1'b1; core_if.req_addr = 10'h030; core_if.req_wdata = 8'h11;
        tick(); @(negedge clk);
        total++; if ({host_if.req_ready, core_if.req_ready} !== 2'b10) begin bad++; $display("FAIL t2_tie1_grant got=%b want=10", {host_if.req_ready, core_if.req_ready}); end
        total++; if (bank_addr !== 10'h020 || bank_re !== 1'b1) begin bad++; $display("FAIL t2_tie1_bank got=%h/%b want=020/1", bank_addr, bank_re); end
        host_if.req_valid = 1'b0;
        tick(); @(negedge clk);
        total++; if (core_if.req_ready !== 1'b0) begin bad++; $display("FAIL t2_core_wait_c2 got=%b want=0", core_if.req_ready); end
        tick(); @(negedge clk);
        total++; if (host_if.rsp_valid !== 1'b1 || host_if.rsp_data !== 8'h77) begin bad++; $display("FAIL t2_host_rsp got=%b/%h want=1/77", host_if.rsp_valid, host_if.rsp_data); end
        total++; if (core_if.req_ready !== 1'b0) begin bad++; $display("FAIL t2_core_wait_c3 got=%b want=0", core_if.req_ready); end
        tick(); tick(); @(negedge clk);
        total++; if (core_if.req_ready !== 1'b1 || bank_we !== 1'b1) begin bad++; $display("FAIL t2_core_write got=%b/%b want=1/1", core_if.req_ready, bank_we); end
        total++; if (bank_addr !== 10'h030 || bank_wdata !== 8'h11) begin bad++; $display("FAIL t2_core_wr_bus got=%h/%h want=030/11", bank_addr, bank_wdata); end
        core_if.req_valid = 1'b0;
        tick();
        host_if.req_valid = 1'b1; host_if.req_write = 1'b1; host_if.req_addr = 10'h040; host_if.req_wdata = 8'h22;
        core_if.req_valid = 1'b1; core_if.req_write = 1'b0; core_if.req_addr = 10'h050;
        tick(); @(negedge clk);
        total++; if ({host_if.req_ready, core_if.req_ready} !== 2'b10) begin bad++; $display("FAIL t2_tie3_grant got=%b want=10", {host_if.req_ready, core_if.req_ready}); end
        total++; if (bank_we !== 1'b1 || bank_addr !== 10'h040) begin bad++; $display("FAIL t2_tie3_bus got=%b/%h want=1/040", bank_we, bank_addr); end
        host_if.req_valid = 1'b0;
        tick(); tick(); @(negedge clk);
        total++; if (core_if.req_ready !== 1'b1 || bank_re !== 1'b1 || bank_addr !== 10'h050) begin bad++; $display("FAIL t2_core_read got=%b/%b/%h want=1/1/050", core_if.req_ready, bank_re, bank_addr); end
        core_if.req_valid = 1'b0;
        tick(); tick(); @(negedge clk);
        total++; if (core_if.rsp_valid !== 1'b1 || core_if.rsp_data !== 8'h77) begin bad++; $display("FAIL t2_core_rsp got=%b/%h want=1/77", core_if.rsp_valid, core_if.rsp_data); end
        total++; if (host_if.rsp_valid !== 1'b0) begin bad++; $display("FAIL t2_host_rsp_idle got=%b want=0", host_if.rsp_valid); end
        tick();
    endtask

    task automatic test_ctrl_protect();
        core_if.req_valid = 1'b1; core_if.req_write = 1'b1; core_if.req_addr = 10'd512; core_if.req_wdata = 8'h03;
        tick(); @(negedge clk);
        total++; if (core_if.req_ready !== 1'b1 || core_wr_reject !== 1'b1) begin bad++; $display("FAIL t3_core_reject got=%b/%b want=1/1", core_if.req_ready, core_wr_reject); end
        total++; if (bank_we !== 1'b0) begin bad++; $display("FAIL t3_core_we got=%b want=0", bank_we); end
        core_if.req_valid = 1'b0;
        tick();
        host_if.req_valid = 1'b1; host_if.req_write = 1'b1; host_if.req_addr = 10'd512; host_if.req_wdata = 8'h03;
        @(negedge clk);
        total++; if (core_wr_reject !== 1'b0) begin bad++; $display("FAIL t3_reject_pulse got=%b want=0", core_wr_reject); end
        tick(); @(negedge clk);
        total++; if (host_if.req_ready !== 1'b1 || bank_we !== 1'b1 || core_wr_reject !== 1'b0) begin bad++; $display("FAIL t3_host_write got=%b/%b/%b want=1/1/0", host_if.req_ready, bank_we, core_wr_reject); end
        total++; if (bank_addr !== 10'd512 || bank_wdata !== 8'h03) begin bad++; $display("FAIL t3_host_bus got=%h/%h want=200/03", bank_addr, bank_wdata); end
        host_if.req_valid = 1'b0;
        tick();
    endtask

    task automatic test_rsp_backpressure();
        bank_rdata = 8'h3C;
        host_if.rsp_ready = 1'b0;
        host_if.req_valid = 1'b1; host_if.req_write = 1'b0; host_if.req_addr = 10'h060;
        tick(); @(negedge clk);
        total++; if (host_if.req_ready !== 1'b1) begin bad++; $display("FAIL t4_host_ready got=%b want=1", host_if.req_ready); end
        host_if.req_valid = 1'b0;
        core_if.req_valid = 1'b1; core_if.req_write = 1'b0; core_if.req_addr = 10'h070;
        tick(); tick();
        bank_rdata = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++; if (host_if.rsp_valid !== 1'b1 || host_if.rsp_data !== 8'h3C) begin bad++; $display("FAIL t4_hold cyc=%0d got=%b/%h want=1/3c", i, host_if.rsp_valid, host_if.rsp_data); end
            total++; if (core_if.req_ready !== 1'b0) begin bad++; $display("FAIL t4_starve cyc=%0d got=%b want=0", i, core_if.req_ready); end
            tick();
        end
        host_if.rsp_ready = 1'b1;
        tick(); @(negedge clk);
        total++; if (host_if.rsp_valid !== 1'b0 || core_if.req_ready !== 1'b0) begin bad++; $display("FAIL t4_after_hs got=%b/%b want=0/0", host_if.rsp_valid, core_if.req_ready); end
        tick(); @(negedge clk);
        total++; if (core_if.req_ready !== 1'b1 || bank_addr !== 10'h070) begin bad++; $display("FAIL t4_core_grant got=%b/%h want=1/070", core_if.req_ready, bank_addr); end
        core_if.req_valid = 1'b0;
        tick(); tick(); @(negedge clk);
        total++; if (core_if.rsp_valid !== 1'b1 || core_if.rsp_data !== 8'hFF) begin bad++; $display("FAIL t4_core_rsp got=%b/%h want=1/ff", core_if.rsp_valid, core_if.rsp_data); end
        tick();
    endtask

    task automatic test_latency3();
        bank_rdata3 = 8'h00;
        h3_if.req_valid = 1'b1; h3_if.req_write = 1'b0; h3_if.req_addr = 10'h0AA;
        tick(); @(negedge clk);
        total++; if (h3_if.req_ready !== 1'b1 || bank_re3 !== 1'b1) begin bad++; $display("FAIL t5_issue got=%b/%b want=1/1", h3_if.req_ready, bank_re3); end
        h3_if.req_valid = 1'b0;
        tick(); tick(); tick();
        bank_rdata3 = 8'hC3;
        @(negedge clk);
        total++; if (h3_if.rsp_valid !== 1'b0) begin bad++; $display("FAIL t5_early_valid got=%b want=0", h3_if.rsp_valid); end
        tick();
        bank_rdata3 = 8'h00;
        @(negedge clk);
        total++; if (h3_if.rsp_valid !== 1'b1 || h3_if.rsp_data !== 8'hC3) begin bad++; $display("FAIL t5_rsp got=%b/%h want=1/c3", h3_if.rsp_valid, h3_if.rsp_data); end
        tick();
    endtask

    task automatic test_reset_in_flight();
        bank_rdata = 8'h99;
        host_if.req_valid = 1'b1; host_if.req_write = 1'b0; host_if.req_addr = 10'h080;
        tick(); @(negedge clk);
        total++; if (host_if.req_ready !== 1'b1) begin bad++; $display("FAIL t6_issue got=%b want=1", host_if.req_ready); end
        host_if.req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (dut_outs() !== 64'd0) begin bad++; $display("FAIL t6_discard cyc=%0d got=%h want=0", i, dut_outs()); end
            tick();
        end
        bank_rdata = 8'h44;
        host_if.req_valid = 1'b1; host_if.req_addr = 10'h081;
        tick(); @(negedge clk);
        total++; if (host_if.req_ready !== 1'b1 || bank_addr !== 10'h081) begin bad++; $display("FAIL t6_reissue got=%b/%h want=1/081", host_if.req_ready, bank_addr); end
        host_if.req_valid = 1'b0;
        tick(); tick(); @(negedge clk);
        total++; if (host_if.rsp_valid !== 1'b1 || host_if.rsp_data !== 8'h44) begin bad++; $display("FAIL t6_rsp got=%b/%h want=1/44", host_if.rsp_valid, host_if.rsp_data); end
        tick();
    endtask

    initial begin
        host_if.req_valid = 1'b0; host_if.req_write = 1'b0; host_if.req_addr = '0; host_if.req_wdata = '0; host_if.rsp_ready = 1'b1;
        core_if.req_valid = 1'b0; core_if.req_write = 1'b0; core_if.req_addr = '0; core_if.req_wdata = '0; core_if.rsp_ready = 1'b1;
        h3_if.req_valid = 1'b0; h3_if.req_write = 1'b0; h3_if.req_addr = '0; h3_if.req_wdata = '0; h3_if.rsp_ready = 1'b1;
        c3_if.req_valid = 1'b0; c3_if.req_write = 1'b0; c3_if.req_addr = '0; c3_if.req_wdata = '0; c3_if.rsp_ready = 1'b1;
        bank_rdata = '0;
        bank_rdata3 = '0;

        test_reset();
        test_round_robin();
        test_ctrl_protect();
        test_rsp_backpressure();
        test_latency3();
        test_reset_in_flight();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before the test sequence completed");
        $fatal(1, "watchdog");
    end

endmodule
